// File: rtl/ov7670_frame_capture_pkg.sv
// ----------------------------------------------------------------------------
// ov7670_cap_pkg
//   Shared types for the OV7670 frame-capture block: capture FSM state and
//   the packed RGB565 / RGB888 pixel formats.
//   No ports (package).
// ----------------------------------------------------------------------------
package ov7670_cap_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        CAPTURE
    } cap_state_e;

    // Field order matches the camera byte order: R in the MSBs.
    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

endpackage

// File: rtl/ov7670_frame_capture_if.sv
// ----------------------------------------------------------------------------
// ov7670_frame_capture_if
//   Bundles the camera bus, capture control, frame-buffer write port and
//   frame status of ov7670_frame_capture.
//   Parameter ADDR_W : write-address width (must equal the capture block's
//                      $clog2(width*height)).
//   slave  modport : capture block side (camera/control in, writes/status out)
//   master modport : camera + memory/controller side
// ----------------------------------------------------------------------------
interface ov7670_frame_capture_if
    import ov7670_cap_pkg::*;
#(
    parameter int unsigned ADDR_W = 19
);
    // Camera bus and control
    logic              ivsync;
    logic              ihref;
    logic [7:0]        idata;
    logic              icapture_en;
    logic [ADDR_W-1:0] ibase_ptr;

    // Frame-buffer write port
    rgb888_t           odata_wr;
    logic [ADDR_W-1:0] oaddr_wr;
    logic              omem_wr_en;

    // Frame status
    logic              oframe_busy;
    logic              oframe_done;
    logic              oframe_err;
    logic [ADDR_W-1:0] oframe_ptr;

    modport slave (
        input  ivsync, ihref, idata, icapture_en, ibase_ptr,
        output odata_wr, oaddr_wr, omem_wr_en,
        output oframe_busy, oframe_done, oframe_err, oframe_ptr
    );

    modport master (
        output ivsync, ihref, idata, icapture_en, ibase_ptr,
        input  odata_wr, oaddr_wr, omem_wr_en,
        input  oframe_busy, oframe_done, oframe_err, oframe_ptr
    );

endinterface

// File: rtl/ov7670_frame_capture_rgb565_expand.sv
// ----------------------------------------------------------------------------
// rgb565_expand
//   Combinational RGB565 -> RGB888 conversion.
//   Macro CAPTURE_RGB888_EXPAND_EN: defined  -> MSB replication per channel
//                                   undefined -> zero padding per channel
//   pix_i : packed RGB565 pixel
//   pix_o : packed RGB888 pixel
// ----------------------------------------------------------------------------
module rgb565_expand
    import ov7670_cap_pkg::*;
(
    input  rgb565_t pix_i,
    output rgb888_t pix_o
);

    always_comb begin
`ifdef CAPTURE_RGB888_EXPAND_EN
        pix_o.r = {pix_i.r, pix_i.r[4:2]};
        pix_o.g = {pix_i.g, pix_i.g[5:4]};
        pix_o.b = {pix_i.b, pix_i.b[4:2]};
`else
        pix_o.r = {pix_i.r, 3'b000};
        pix_o.g = {pix_i.g, 2'b00};
        pix_o.b = {pix_i.b, 3'b000};
`endif
    end

endmodule

// File: rtl/ov7670_frame_capture.sv
// ----------------------------------------------------------------------------
// ov7670_frame_capture
//   Captures OV7670 RGB565 frames from the 8-bit camera bus and writes RGB888
//   pixels to a linear frame buffer starting at a per-frame base pointer.
//   A frame ends at the next vsync rising edge: oframe_done (clean) or
//   oframe_err (geometry error) pulses, and oframe_ptr reports the base of
//   the last clean frame.
//   Macro CAPTURE_RGB888_EXPAND_EN selects the 565->888 expansion rule
//   (see rgb565_expand).
//   Ports:
//     iclk : camera pixel clock (only clock)
//     irst : asynchronous active-high reset
//     cam  : ov7670_frame_capture_if.slave (camera bus, control, write port,
//            frame status)
// ----------------------------------------------------------------------------
module ov7670_frame_capture
    import ov7670_cap_pkg::*;
#(
    parameter int unsigned pIM_WIDTH  = 640,
    parameter int unsigned pIM_HEIGHT = 480,
    parameter bit          pVSYNC_POL = 1'b1
) (
    input  logic                  iclk,
    input  logic                  irst,
    ov7670_frame_capture_if.slave cam
);

    localparam int unsigned lpADDR_W = $clog2(pIM_WIDTH * pIM_HEIGHT);
    localparam int unsigned lpCOL_W  = $clog2(pIM_WIDTH + 1);
    localparam int unsigned lpLINE_W = $clog2(pIM_HEIGHT + 1);

    localparam logic [lpADDR_W-1:0] lpW_ADDR   = lpADDR_W'(pIM_WIDTH);
    localparam logic [lpADDR_W-1:0] lpADDR_ONE = lpADDR_W'(1);
    localparam logic [lpCOL_W-1:0]  lpW_COL    = lpCOL_W'(pIM_WIDTH);
    localparam logic [lpCOL_W-1:0]  lpCOL_ONE  = lpCOL_W'(1);
    localparam logic [lpCOL_W-1:0]  lpCOL_MAX  = '1;
    localparam logic [lpLINE_W-1:0] lpH_LINE   = lpLINE_W'(pIM_HEIGHT);
    localparam logic [lpLINE_W-1:0] lpLINE_ONE = lpLINE_W'(1);
    localparam logic [lpLINE_W-1:0] lpLINE_MAX = '1;

    cap_state_e            state_q, state_d;
    logic                  vsync_q;
    logic                  href_q;
    logic                  phase_q, phase_d;
    logic [7:0]            hi_q, hi_d;
    logic [lpCOL_W-1:0]    col_q, col_d;
    logic [lpLINE_W-1:0]   line_q, line_d;
    logic                  geom_q, geom_d;
    logic [lpADDR_W-1:0]   base_q, base_d;
    logic [lpADDR_W-1:0]   lbase_q, lbase_d;
    logic [lpADDR_W-1:0]   wptr_q, wptr_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [lpADDR_W-1:0]   ptr_q, ptr_d;
    logic                  wr_en_q, wr_en_d;
    logic [lpADDR_W-1:0]   addr_q, addr_d;
    rgb888_t               data_q, data_d;

    logic                  vs_act, vs_rise, href_fall, arm;
    rgb565_t               px565;
    rgb888_t               px888;

    assign vs_act    = (cam.ivsync == pVSYNC_POL);
    assign vs_rise   = vs_act && (vsync_q != pVSYNC_POL);
    assign href_fall = href_q && !cam.ihref;
    assign px565     = rgb565_t'({hi_q, cam.idata});

    rgb565_expand u_expand (
        .pix_i (px565),
        .pix_o (px888)
    );

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            state_q <= IDLE;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            phase_q <= 1'b0;
            hi_q    <= '0;
            col_q   <= '0;
            line_q  <= '0;
            geom_q  <= 1'b0;
            base_q  <= '0;
            lbase_q <= '0;
            wptr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ptr_q   <= '0;
            wr_en_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            vsync_q <= cam.ivsync;
            href_q  <= cam.ihref;
            phase_q <= phase_d;
            hi_q    <= hi_d;
            col_q   <= col_d;
            line_q  <= line_d;
            geom_q  <= geom_d;
            base_q  <= base_d;
            lbase_q <= lbase_d;
            wptr_q  <= wptr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ptr_q   <= ptr_d;
            wr_en_q <= wr_en_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        hi_d    = hi_q;
        col_d   = col_q;
        line_d  = line_q;
        geom_d  = geom_q;
        base_d  = base_q;
        lbase_d = lbase_q;
        wptr_d  = wptr_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        ptr_d   = ptr_q;
        wr_en_d = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        arm     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (vs_rise && cam.icapture_en) begin
                    state_d = SYNC;
                    busy_d  = 1'b1;
                    arm     = 1'b1;
                end
            end

            SYNC: begin
                if (!vs_act) begin
                    state_d = CAPTURE;
                end
            end

            CAPTURE: begin
                if (cam.ihref) begin
                    if (!phase_q) begin
                        hi_d    = cam.idata;
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if ((col_q < lpW_COL) && (line_q < lpH_LINE)) begin
                            wr_en_d = 1'b1;
                            addr_d  = wptr_q;
                            data_d  = px888;
                            wptr_d  = wptr_q + lpADDR_ONE;
                        end
                        // Clipped pixels still count so overlong lines are seen.
                        if (col_q != lpCOL_MAX) begin
                            col_d = col_q + lpCOL_ONE;
                        end
                    end
                end else if (href_fall) begin
                    if (line_q != lpLINE_MAX) begin
                        line_d = line_q + lpLINE_ONE;
                    end
                    if ((col_q != lpW_COL) || phase_q) begin
                        geom_d = 1'b1;
                    end
                    col_d   = '0;
                    phase_d = 1'b0;
                    // Line base advances by W regardless of how many pixels
                    // this line wrote, keeping wr_ptr = base + line*W + col.
                    lbase_d = lbase_q + lpW_ADDR;
                    wptr_d  = lbase_q + lpW_ADDR;
                end

                // Judged on the _d values so a line end or pixel landing on
                // the vsync edge is included in this frame.
                if (vs_rise) begin
                    if ((line_d == lpH_LINE) && !geom_d) begin
                        done_d = 1'b1;
                        ptr_d  = base_q;
                    end else begin
                        err_d = 1'b1;
                    end
                    if (cam.icapture_en) begin
                        state_d = SYNC;
                        arm     = 1'b1;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        phase_d = 1'b0;
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        if (arm) begin
            base_d  = cam.ibase_ptr;
            lbase_d = cam.ibase_ptr;
            wptr_d  = cam.ibase_ptr;
            col_d   = '0;
            line_d  = '0;
            geom_d  = 1'b0;
            phase_d = 1'b0;
        end
    end

    assign cam.odata_wr    = data_q;
    assign cam.oaddr_wr    = addr_q;
    assign cam.omem_wr_en  = wr_en_q;
    assign cam.oframe_busy = busy_q;
    assign cam.oframe_done = done_q;
    assign cam.oframe_err  = err_q;
    assign cam.oframe_ptr  = ptr_q;

endmodule

// File: tb/tb_ov7670_frame_capture.sv
// ----------------------------------------------------------------------------
// tb_ov7670_frame_capture
//   Directed + randomized bench for ov7670_frame_capture with W=4, H=2
//   (3-bit addresses, so a base of 0x10 maps to 0 and frames wrap).
//   Expected writes/status come from a frame-level reference model: each
//   line's bytes are paired into pixels, placed at base + line*W + col, and
//   the frame is judged clean if it has exactly H lines of exactly W pixels.
// ----------------------------------------------------------------------------
module tb_ov7670_frame_capture;

    localparam int unsigned W  = 4;
    localparam int unsigned H  = 2;
    localparam int unsigned AW = $clog2(W * H);
    typedef logic [AW-1:0] addr_t;

    logic iclk = 1'b0;
    logic irst = 1'b1;

    ov7670_frame_capture_if #(.ADDR_W(AW)) cam ();

    ov7670_frame_capture #(
        .pIM_WIDTH  (W),
        .pIM_HEIGHT (H),
        .pVSYNC_POL (1'b1)
    ) dut (
        .iclk (iclk),
        .irst (irst),
        .cam  (cam)
    );

    always #5 iclk = ~iclk;

    int n_vec  = 0;
    int n_fail = 0;

    // Monitor: what the DUT actually did, sampled on the falling edge.
    addr_t       mon_addr[$];
    logic [23:0] mon_data[$];
    int          done_cnt = 0;
    int          err_cnt  = 0;
    addr_t       done_ptr = '0;

    always @(negedge iclk) begin
        if (cam.omem_wr_en === 1'b1) begin
            mon_addr.push_back(cam.oaddr_wr);
            mon_data.push_back(cam.odata_wr);
        end
        if (cam.oframe_done === 1'b1) begin
            done_cnt++;
            done_ptr = cam.oframe_ptr;
        end
        if (cam.oframe_err === 1'b1) err_cnt++;
    end

    // Reference model state
    addr_t       exp_addr[$];
    logic [23:0] exp_data[$];
    bit          m_active = 1'b0;
    addr_t       m_base   = '0;
    int          m_line   = 0;
    bit          m_bad    = 1'b0;
    addr_t       m_ptr    = '0;
    logic [7:0]  line_buf [0:31];

    function automatic logic [23:0] ref_px(input logic [7:0] hi, input logic [7:0] lo);
        int r5, g6, b5, r8, g8, b8;
        r5 = int'(hi) / 8;
        g6 = (int'(hi) % 8) * 8 + int'(lo) / 32;
        b5 = int'(lo) % 32;
`ifdef CAPTURE_RGB888_EXPAND_EN
        r8 = r5 * 8 + r5 / 4;
        g8 = g6 * 4 + g6 / 16;
        b8 = b5 * 8 + b5 / 4;
`else
        r8 = r5 * 8;
        g8 = g6 * 4;
        b8 = b5 * 8;
`endif
        return 24'(r8 * 65536 + g8 * 256 + b8);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) line_buf[i] = 8'($urandom_range(0, 255));
    endtask

    // Sends line_buf[0..n-1] as one href line, then a 3-cycle gap.
    task automatic send_line(input int n);
        int p;
        for (int i = 0; i < n; i++) begin
            cam.ihref = 1'b1;
            cam.idata = line_buf[i];
            tick();
        end
        cam.ihref = 1'b0;
        cam.idata = 8'h00;
        repeat (3) tick();
        if (m_active) begin
            p = n / 2;
            if ((p != int'(W)) || (n % 2 != 0)) m_bad = 1'b1;
            for (int k = 0; k < p; k++) begin
                if ((k < int'(W)) && (m_line < int'(H))) begin
                    exp_addr.push_back(addr_t'((int'(m_base) + m_line * int'(W) + k) % (1 << AW)));
                    exp_data.push_back(ref_px(line_buf[2*k], line_buf[2*k+1]));
                end
            end
            m_line++;
        end
    endtask

    // Vsync pulse: closes the running frame (checked here) and, if en,
    // opens the next one at new_base.
    task automatic boundary(input addr_t new_base, input logic en);
        bit exp_done, exp_err;
        cam.ibase_ptr   = new_base;
        cam.icapture_en = en;
        cam.ivsync      = 1'b1;
        tick();
        tick();
        cam.ivsync      = 1'b0;
        tick();
        tick();
        exp_done = m_active && (m_line == int'(H)) && !m_bad;
        exp_err  = m_active && !exp_done;
        chk("wr_count", 32'(mon_addr.size()), 32'(exp_addr.size()));
        for (int k = 0; k < exp_addr.size() && k < mon_addr.size(); k++) begin
            chk($sformatf("wr_addr[%0d]", k), 32'(mon_addr[k]), 32'(exp_addr[k]));
            chk($sformatf("wr_data[%0d]", k), 32'(mon_data[k]), 32'(exp_data[k]));
        end
        chk("done_cnt", 32'(done_cnt), 32'(exp_done));
        chk("err_cnt", 32'(err_cnt), 32'(exp_err));
        if (exp_done) begin
            m_ptr = m_base;
            chk("done_ptr", 32'(done_ptr), 32'(m_base));
        end
        chk("frame_ptr", 32'(cam.oframe_ptr), 32'(m_ptr));
        chk("busy", 32'(cam.oframe_busy), 32'(en));
        mon_addr.delete();
        mon_data.delete();
        exp_addr.delete();
        exp_data.delete();
        done_cnt = 0;
        err_cnt  = 0;
        m_active = en;
        m_base   = new_base;
        m_line   = 0;
        m_bad    = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_data"},  32'(cam.odata_wr),    32'h0);
        chk({tag, "_addr"},  32'(cam.oaddr_wr),    32'h0);
        chk({tag, "_wr_en"}, 32'(cam.omem_wr_en),  32'h0);
        chk({tag, "_busy"},  32'(cam.oframe_busy), 32'h0);
        chk({tag, "_done"},  32'(cam.oframe_done), 32'h0);
        chk({tag, "_err"},   32'(cam.oframe_err),  32'h0);
        chk({tag, "_ptr"},   32'(cam.oframe_ptr),  32'h0);
    endtask

    logic [7:0] clean_tbl [0:7] = '{8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F, 8'hFF, 8'hFF};

    initial begin
        cam.ivsync      = 1'b0;
        cam.ihref       = 1'b0;
        cam.idata       = 8'h00;
        cam.icapture_en = 1'b0;
        cam.ibase_ptr   = '0;

        // Reset state
        repeat (3) tick();
        check_outputs_zero("reset");
        irst = 1'b0;
        tick();

        // Clean frame with the directed colour table (base 0x10 -> 0 in 3 bits)
        boundary(addr_t'(32'h10), 1'b1);
        for (int i = 0; i < 8; i++) line_buf[i] = clean_tbl[i];
        send_line(8);
        send_line(8);

        // Randomized clean frames at random (wrapping) bases
        for (int f = 0; f < 3; f++) begin
            boundary(addr_t'($urandom_range(0, 7)), 1'b1);
            fill_random(8);
            send_line(8);
            fill_random(8);
            send_line(8);
        end

        // Short line: 3 pixels on the first line
        boundary(addr_t'($urandom_range(0, 7)), 1'b1);
        fill_random(6);
        send_line(6);
        fill_random(8);
        send_line(8);

        // Overlong frame: 3 lines of 5 pixels
        boundary(addr_t'($urandom_range(0, 7)), 1'b1);
        for (int l = 0; l < 3; l++) begin
            fill_random(10);
            send_line(10);
        end

        // Odd byte count: 9 bytes on the first line
        boundary(addr_t'($urandom_range(0, 7)), 1'b1);
        fill_random(9);
        send_line(9);
        fill_random(8);
        send_line(8);

        // Disarm mid-frame: frame completes, then capture stays off
        boundary(addr_t'($urandom_range(0, 7)), 1'b1);
        fill_random(8);
        send_line(8);
        cam.icapture_en = 1'b0;
        fill_random(8);
        send_line(8);
        boundary(addr_t'($urandom_range(0, 7)), 1'b0);
        fill_random(8);
        send_line(8);
        boundary(addr_t'($urandom_range(0, 7)), 1'b0);

        // Reset mid-frame right after the third write
        boundary(addr_t'($urandom_range(0, 7)), 1'b1);
        for (int i = 0; i < 6; i++) begin
            cam.ihref = 1'b1;
            cam.idata = 8'($urandom_range(0, 255));
            tick();
        end
        chk("pre_rst_wr_en", 32'(cam.omem_wr_en), 32'h1);
        irst      = 1'b1;
        cam.ihref = 1'b0;
        #1;
        check_outputs_zero("midrst");
        tick();
        tick();
        irst = 1'b0;
        repeat (3) tick();
        chk("midrst_done_cnt", 32'(done_cnt), 32'h0);
        chk("midrst_err_cnt", 32'(err_cnt), 32'h0);
        mon_addr.delete();
        mon_data.delete();
        exp_addr.delete();
        exp_data.delete();
        m_active = 1'b0;
        m_ptr    = '0;
        // Lines before a fresh vsync are ignored
        fill_random(8);
        send_line(8);
        boundary(addr_t'($urandom_range(0, 7)), 1'b1);
        fill_random(8);
        send_line(8);
        fill_random(8);
        send_line(8);
        boundary(addr_t'($urandom_range(0, 7)), 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
